hazard_stall_controller: RTL and testbench

- Pipeline hazard and stall sequencer for the 5-stage MIPS core. It sits beside the forwarding logic in the ID/EX boundary.
- Resolves the hazards that forwarding cannot cover:
  - load-use: one bubble.
  - taken branch/jump resolved in EX: flush of IF/ID and ID/EX.
  - multi-cycle multiply/divide in EX: freeze of the front end for MDU_LATENCY cycles.
- Drives the PC, IF/ID and ID/EX write enables and the bubble/flush controls.

---
 rtl/hazard_pkg.sv | 17 +
 rtl/mdu_latency_counter.sv | 37 +++
 rtl/hazard_stall_controller.sv | 166 ++++++++++++++++
 tb/tb_hazard_stall_controller.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard/stall sequencer.
package hazard_pkg;

    // Controller state encodings
    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_LDUSE = 2'b01,
        ST_MDU   = 2'b10
    } hz_state_e;

    // Architectural zero register never carries a true dependency
    localparam logic [4:0] REG_ZERO = 5'd0;

    // Width of the MDU occupancy counter (covers MDU_LATENCY up to 15)
    localparam int unsigned MDU_CNT_W = 4;

endpackage : hazard_pkg

// File: rtl/mdu_latency_counter.sv
// Down-counter tracking remaining MDU occupancy cycles; flags the final cycle.
module mdu_latency_counter
    import hazard_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load_i,
    input  logic [MDU_CNT_W-1:0] load_val_i,
    input  logic                 dec_i,
    output logic                 tc_o
);

    logic [MDU_CNT_W-1:0] cnt_q;
    logic [MDU_CNT_W-1:0] cnt_d;

    // Load has priority over decrement; decrement stops at zero
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != MDU_CNT_W'(0))) begin
            cnt_d = cnt_q - MDU_CNT_W'(1);
        end
    end

    // Counter register, cleared asynchronously so a reset aborts any MDU run
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == MDU_CNT_W'(1));

endmodule : mdu_latency_counter

// File: rtl/hazard_stall_controller.sv
// Hazard and stall sequencer for the 5-stage pipeline: load-use bubble,
// taken-branch flush and multi-cycle MDU front-end freeze.
// Optional stall performance counter enabled by HAZARD_STALL_PERF_CNT_EN.
module hazard_stall_controller
    import hazard_pkg::*;
#(
    parameter int unsigned MDU_LATENCY = 4,
    parameter int unsigned REG_ADDR_W  = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_ID_EX_MemRead,
    input  logic [REG_ADDR_W-1:0] in_ID_EX_Rt_address_5,
    input  logic [REG_ADDR_W-1:0] in_IF_ID_Rs_address_5,
    input  logic [REG_ADDR_W-1:0] in_IF_ID_Rt_address_5,
    input  logic                  in_IF_ID_uses_rt,
    input  logic                  in_EX_branch_taken,
    input  logic                  in_EX_mdu_start,
    output logic                  o_PC_write,
    output logic                  o_IF_ID_write,
    output logic                  o_ID_EX_write,
    output logic                  o_IF_ID_flush,
    output logic                  o_ID_EX_bubble,
    output logic                  o_EX_MEM_bubble,
    output logic                  o_mdu_busy,
    output logic                  o_mdu_done,
    output logic [31:0]           o_stall_cycles_32
);

    localparam logic [MDU_CNT_W-1:0] MDU_LOAD = MDU_CNT_W'(MDU_LATENCY - 1);

    hz_state_e state_q;
    hz_state_e state_d;

    logic load_use_hit;
    logic cnt_load;
    logic cnt_dec;
    logic cnt_tc;

    // Load in EX writes a register the ID instruction reads (r0 excluded)
    always_comb begin
        load_use_hit = in_ID_EX_MemRead
                    && (in_ID_EX_Rt_address_5 != REG_ADDR_W'(REG_ZERO))
                    && ((in_ID_EX_Rt_address_5 == in_IF_ID_Rs_address_5)
                     || (in_IF_ID_uses_rt
                      && (in_ID_EX_Rt_address_5 == in_IF_ID_Rt_address_5)));
    end

    // Next-state and Mealy outputs; reset forces every control inactive
    always_comb begin
        state_d         = state_q;
        o_PC_write      = 1'b1;
        o_IF_ID_write   = 1'b1;
        o_ID_EX_write   = 1'b1;
        o_IF_ID_flush   = 1'b0;
        o_ID_EX_bubble  = 1'b0;
        o_EX_MEM_bubble = 1'b0;
        o_mdu_busy      = 1'b0;
        o_mdu_done      = 1'b0;
        cnt_load        = 1'b0;
        cnt_dec         = 1'b0;

        unique case (state_q)
            ST_RUN: begin
                if (in_EX_branch_taken) begin
                    o_IF_ID_flush  = 1'b1;
                    o_ID_EX_bubble = 1'b1;
                end else if (in_EX_mdu_start) begin
                    o_PC_write      = 1'b0;
                    o_IF_ID_write   = 1'b0;
                    o_ID_EX_write   = 1'b0;
                    o_EX_MEM_bubble = 1'b1;
                    o_mdu_busy      = 1'b1;
                    cnt_load        = 1'b1;
                    state_d         = ST_MDU;
                end else if (load_use_hit) begin
                    o_PC_write     = 1'b0;
                    o_IF_ID_write  = 1'b0;
                    o_ID_EX_bubble = 1'b1;
                    state_d        = ST_LDUSE;
                end
            end
            ST_LDUSE: begin
                // Bubble already in EX: only a taken branch matters here
                if (in_EX_branch_taken) begin
                    o_IF_ID_flush  = 1'b1;
                    o_ID_EX_bubble = 1'b1;
                end
                state_d = ST_RUN;
            end
            ST_MDU: begin
                o_PC_write      = 1'b0;
                o_IF_ID_write   = 1'b0;
                o_ID_EX_write   = 1'b0;
                o_EX_MEM_bubble = 1'b1;
                o_mdu_busy      = 1'b1;
                cnt_dec         = 1'b1;
                if (cnt_tc) begin
                    o_mdu_done = 1'b1;
                    state_d    = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        if (reset) begin
            o_PC_write      = 1'b0;
            o_IF_ID_write   = 1'b0;
            o_ID_EX_write   = 1'b0;
            o_IF_ID_flush   = 1'b0;
            o_ID_EX_bubble  = 1'b0;
            o_EX_MEM_bubble = 1'b0;
            o_mdu_busy      = 1'b0;
            o_mdu_done      = 1'b0;
            cnt_load        = 1'b0;
            cnt_dec         = 1'b0;
        end
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Remaining-cycle tracker for the MDU freeze
    mdu_latency_counter u_mdu_cnt (
        .clk        (clk),
        .reset      (reset),
        .load_i     (cnt_load),
        .load_val_i (MDU_LOAD),
        .dec_i      (cnt_dec),
        .tc_o       (cnt_tc)
    );

`ifdef HAZARD_STALL_PERF_CNT_EN
    logic [31:0] stall_cnt_q;

    // Count front-end stall cycles (PC held); saturates, cleared by reset only
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else if (!o_PC_write && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign o_stall_cycles_32 = stall_cnt_q;
`else
    assign o_stall_cycles_32 = '0;
`endif

`ifndef SYNTHESIS
    // Branch and MDU start can never both be valid in EX
    a_no_branch_with_mdu_start : assert property (
        @(posedge clk) disable iff (reset)
        (state_q == ST_RUN) |-> !(in_EX_branch_taken && in_EX_mdu_start)
    ) else $error("branch_taken and mdu_start asserted together");
`endif

endmodule : hazard_stall_controller

// File: tb/tb_hazard_stall_controller.sv
// Scoreboard bench for hazard_stall_controller (MDU_LATENCY=4).
module tb_hazard_stall_controller;

    logic        clk;
    logic        reset;
    logic        mem_read;
    logic [4:0]  ex_rt;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        uses_rt;
    logic        br_taken;
    logic        mdu_start;
    logic        pc_w, ifid_w, idex_w, ifid_flush, idex_bub, exmem_bub, busy, done;
    logic [31:0] stall_cnt;

    int checks;
    int errors;
    int stalls_model;
    bit stim_done;

    logic [7:0]  exp_ctl_q[$];
    logic [31:0] exp_cnt_q[$];
    string       exp_name_q[$];

    // {pc, ifid, idex, flush, idex_bubble, exmem_bubble, busy, done}
    localparam logic [7:0] E_DEF  = 8'b1110_0000;
    localparam logic [7:0] E_LU   = 8'b0010_1000;
    localparam logic [7:0] E_BR   = 8'b1111_1000;
    localparam logic [7:0] E_MDU  = 8'b0000_0110;
    localparam logic [7:0] E_DONE = 8'b0000_0111;
    localparam logic [7:0] E_RST  = 8'b0000_0000;

    hazard_stall_controller #(
        .MDU_LATENCY (4),
        .REG_ADDR_W  (5)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .in_ID_EX_MemRead      (mem_read),
        .in_ID_EX_Rt_address_5 (ex_rt),
        .in_IF_ID_Rs_address_5 (id_rs),
        .in_IF_ID_Rt_address_5 (id_rt),
        .in_IF_ID_uses_rt      (uses_rt),
        .in_EX_branch_taken    (br_taken),
        .in_EX_mdu_start       (mdu_start),
        .o_PC_write            (pc_w),
        .o_IF_ID_write         (ifid_w),
        .o_ID_EX_write         (idex_w),
        .o_IF_ID_flush         (ifid_flush),
        .o_ID_EX_bubble        (idex_bub),
        .o_EX_MEM_bubble       (exmem_bub),
        .o_mdu_busy            (busy),
        .o_mdu_done            (done),
        .o_stall_cycles_32     (stall_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one cycle of inputs at the falling edge and queue its expectation
    task automatic step(input logic rst_v, input logic mr, input logic [4:0] rt_ex,
                        input logic [4:0] rs_id, input logic [4:0] rt_id,
                        input logic ur, input logic br, input logic ms,
                        input logic [7:0] exp, input string name);
        logic [31:0] exp_cnt;
        @(negedge clk);
        reset     = rst_v;
        mem_read  = mr;
        ex_rt     = rt_ex;
        id_rs     = rs_id;
        id_rt     = rt_id;
        uses_rt   = ur;
        br_taken  = br;
        mdu_start = ms;
        if (rst_v) begin
            stalls_model = 0;
            exp_cnt      = 32'd0;
        end else begin
            exp_cnt = 32'(stalls_model);
            if (!exp[7]) stalls_model++;
        end
`ifndef HAZARD_STALL_PERF_CNT_EN
        exp_cnt = 32'd0;
`endif
        exp_ctl_q.push_back(exp);
        exp_cnt_q.push_back(exp_cnt);
        exp_name_q.push_back(name);
    endtask

    task automatic idle(input logic [7:0] exp, input string name);
        step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, exp, name);
    endtask

    // Monitor: compare DUT outputs mid-cycle, well before the next rising edge
    initial begin
        logic [7:0]  got;
        logic [7:0]  e_ctl;
        logic [31:0] e_cnt;
        string       nm;
        forever begin
            @(negedge clk);
            #2;
            if (exp_ctl_q.size() > 0) begin
                e_ctl = exp_ctl_q.pop_front();
                e_cnt = exp_cnt_q.pop_front();
                nm    = exp_name_q.pop_front();
                got = {pc_w, ifid_w, idex_w, ifid_flush, idex_bub, exmem_bub, busy, done};
                checks++;
                if (got !== e_ctl) begin
                    errors++;
                    $display("FAIL %s ctl got %b exp %b", nm, got, e_ctl);
                end
                checks++;
                if (stall_cnt !== e_cnt) begin
                    errors++;
                    $display("FAIL %s stall_cnt got %0d exp %0d", nm, stall_cnt, e_cnt);
                end
            end
        end
    end

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        checks = 0; errors = 0; stalls_model = 0; stim_done = 1'b0;
        reset = 1'b1; mem_read = 1'b0; ex_rt = '0; id_rs = '0; id_rt = '0;
        uses_rt = 1'b0; br_taken = 1'b0; mdu_start = 1'b0;

        step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, E_RST, "reset");
        idle(E_DEF, "run_default");
        // load-use on Rs, then masked second cycle, then RUN
        step(1'b0, 1'b1, 5'd8, 5'd8, 5'd1, 1'b0, 1'b0, 1'b0, E_LU,  "lu_rs");
        step(1'b0, 1'b1, 5'd8, 5'd8, 5'd1, 1'b0, 1'b0, 1'b0, E_DEF, "lu_masked");
        // zero register and uses_rt gating
        step(1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, E_DEF, "rt_zero");
        step(1'b0, 1'b1, 5'd9, 5'd3, 5'd9, 1'b0, 1'b0, 1'b0, E_DEF, "rt_no_use");
        step(1'b0, 1'b1, 5'd9, 5'd3, 5'd9, 1'b1, 1'b0, 1'b0, E_LU,  "rt_use");
        idle(E_DEF, "ldu_after_rt");
        // branch beats load-use; stays RUN so a fresh load-use stalls at once
        step(1'b0, 1'b1, 5'd8, 5'd8, 5'd1, 1'b0, 1'b1, 1'b0, E_BR,  "br_prec");
        step(1'b0, 1'b1, 5'd8, 5'd8, 5'd1, 1'b0, 1'b0, 1'b0, E_LU,  "lu_after_br");
        // branch honoured in the LDUSE cycle
        step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, E_BR,  "br_in_ldu");
        idle(E_DEF, "run_after_ldu_br");
        // MDU sequence: 4 busy cycles, done only in the last; hazards ignored
        step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, E_MDU,  "mdu_c1");
        step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, E_MDU,  "mdu_c2_br");
        step(1'b0, 1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b1, E_MDU,  "mdu_c3_lu");
        idle(E_DONE, "mdu_c4_done");
        idle(E_DEF,  "mdu_exit");
        // reset in MDU cycle 2 must clear outputs before the next edge
        step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, E_MDU, "mdu2_c1");
        step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, E_RST, "rst_mid_mdu");
        step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, E_RST, "rst_hold");
        idle(E_DEF, "post_rst_1");
        idle(E_DEF, "post_rst_2");
        idle(E_DEF, "post_rst_3");
        // one load-use plus one MDU(4): five stall cycles
        step(1'b0, 1'b1, 5'd4, 5'd4, 5'd0, 1'b0, 1'b0, 1'b0, E_LU, "perf_lu");
        idle(E_DEF, "perf_ldu");
        step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, E_MDU, "perf_m1");
        idle(E_MDU,  "perf_m2");
        idle(E_MDU,  "perf_m3");
        idle(E_DONE, "perf_m4");
        idle(E_DEF,  "perf_total");
        idle(E_DEF,  "perf_hold");

        repeat (3) @(negedge clk);
        #4;
        checks++;
        if (exp_ctl_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending %0d exp 0", exp_ctl_q.size());
        end
        stim_done = 1'b1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_hazard_stall_controller
